// File: rtl/hdmi_video_timing.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_video_timing
// Description : CEA-861 raster generator (h/v counters with registered sync,
//               data-enable, coordinates and line/frame strobes).
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_video_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk_pix,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam logic [XW-1:0] C_H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] C_H_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] C_HS_BEGIN = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] C_HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW-1:0] C_V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] C_V_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] C_VS_BEGIN = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] C_VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
      $fatal(1, "hdmi_video_timing: every H_* and V_* parameter must be >= 1");
    end
  endgenerate

  logic [XW-1:0] h_cnt_q, h_cnt_d;
  logic [YW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (en) begin
      // Outputs decode the counter value held before this edge: one-cycle latency.
      de_d          = (h_cnt_q < C_H_ACT) && (v_cnt_q < C_V_ACT);
      hsync_d       = ((h_cnt_q >= C_HS_BEGIN) && (h_cnt_q < C_HS_END)) ? HS_POL : ~HS_POL;
      vsync_d       = ((v_cnt_q >= C_VS_BEGIN) && (v_cnt_q < C_VS_END)) ? VS_POL : ~VS_POL;
      x_d           = h_cnt_q;
      y_d           = v_cnt_q;
      line_start_d  = (h_cnt_q == '0);
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

      if (h_cnt_q == C_H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == C_V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_video_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_video_timing
// Description : Self-checking bench: two reduced raster modes (positive and
//               negative sync polarity) against a linear-index reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_video_timing;

  // Mode A: positive polarity, 32 x 19 raster
  localparam int HA_A = 20, HF_A = 3, HS_A = 4, HB_A = 5;
  localparam int VA_A = 10, VF_A = 2, VS_A = 3, VB_A = 4;
  localparam int HT_A = HA_A + HF_A + HS_A + HB_A;
  localparam int VT_A = VA_A + VF_A + VS_A + VB_A;
  localparam int TOT_A = HT_A * VT_A;
  // Mode B: negative polarity, 28 x 18 raster
  localparam int HA_B = 16, HF_B = 2, HS_B = 6, HB_B = 4;
  localparam int VA_B = 12, VF_B = 1, VS_B = 2, VB_B = 3;
  localparam int HT_B = HA_B + HF_B + HS_B + HB_B;
  localparam int VT_B = VA_B + VF_B + VS_B + VB_B;
  localparam int TOT_B = HT_B * VT_B;

  logic clk_pix = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;

  logic       hsync_a, vsync_a, de_a, ls_a, fs_a;
  logic [4:0] x_a, y_a;
  logic       hsync_b, vsync_b, de_b, ls_b, fs_b;
  logic [4:0] x_b, y_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk_pix = ~clk_pix;

  hdmi_video_timing #(
    .H_ACTIVE(HA_A), .H_FP(HF_A), .H_SYNC(HS_A), .H_BP(HB_A),
    .V_ACTIVE(VA_A), .V_FP(VF_A), .V_SYNC(VS_A), .V_BP(VB_A),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_a (
    .clk_pix(clk_pix), .rst(rst), .en(en),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  hdmi_video_timing #(
    .H_ACTIVE(HA_B), .H_FP(HF_B), .H_SYNC(HS_B), .H_BP(HB_B),
    .V_ACTIVE(VA_B), .V_FP(VF_B), .V_SYNC(VS_B), .V_BP(VB_B),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_b (
    .clk_pix(clk_pix), .rst(rst), .en(en),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  wire [14:0] obs_a = {hsync_a, vsync_a, de_a, ls_a, fs_a, x_a, y_a};
  wire [14:0] obs_b = {hsync_b, vsync_b, de_b, ls_b, fs_b, x_b, y_b};

  localparam logic [14:0] RST_A = 15'h0000;
  localparam logic [14:0] RST_B = 15'h6000;

  // Reference: raster position as one linear index p = v*H_TOTAL + h.
  function automatic logic [14:0] model_out(int p, int ha, int hf, int hs, int hb,
                                            int va, int vf, int vs, bit hp, bit vp);
    int ht, h, v;
    logic hsv, vsv, dev;
    ht  = ha + hf + hs + hb;
    h   = p % ht;
    v   = p / ht;
    dev = (h < ha) && (v < va);
    hsv = (h >= ha + hf && h < ha + hf + hs) ? hp : ~hp;
    vsv = (v >= va + vf && v < va + vf + vs) ? vp : ~vp;
    return {hsv, vsv, dev, (h == 0), (p == 0), 5'(h), 5'(v)};
  endfunction

  int pa, pb;
  logic [14:0] ea, eb;

  always @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      pa <= 0; pb <= 0;
      ea <= RST_A; eb <= RST_B;
    end else if (en) begin
      ea <= model_out(pa, HA_A, HF_A, HS_A, HB_A, VA_A, VF_A, VS_A, 1'b1, 1'b1);
      eb <= model_out(pb, HA_B, HF_B, HS_B, HB_B, VA_B, VF_B, VS_B, 1'b0, 1'b0);
      pa <= (pa + 1) % TOT_A;
      pb <= (pb + 1) % TOT_B;
    end else begin
      ea <= {ea[14:12], 2'b00, ea[9:0]};
      eb <= {eb[14:12], 2'b00, eb[9:0]};
    end
  end

  task automatic tick();
    @(negedge clk_pix);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    tick(); tick();
    checks++; if (obs_a !== RST_A) begin errors++; $display("FAIL reset_a: got %h want %h", obs_a, RST_A); end
    checks++; if (obs_b !== RST_B) begin errors++; $display("FAIL reset_b_idle_high: got %h want %h", obs_b, RST_B); end
    en = 1'b1;
    tick();
    checks++; if (obs_a !== RST_A) begin errors++; $display("FAIL reset_hold_en_a: got %h want %h", obs_a, RST_A); end
    checks++; if (obs_b !== RST_B) begin errors++; $display("FAIL reset_hold_en_b: got %h want %h", obs_b, RST_B); end
  endtask

  task automatic test_startup();
    rst = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (!(de_a === 1'b1 && ls_a === 1'b1 && fs_a === 1'b1 && x_a === 5'd0 && y_a === 5'd0)) begin
      errors++; $display("FAIL startup_a: got de=%b ls=%b fs=%b x=%0d y=%0d want 1 1 1 0 0", de_a, ls_a, fs_a, x_a, y_a);
    end
    checks++; if (obs_b !== eb) begin errors++; $display("FAIL startup_b: got %h want %h", obs_b, eb); end
  endtask

  task automatic test_full_frames();
    int last_fs, periods, de_cnt, vs_cnt, line_idx, line_de, line_hs, line_cyc;
    int last_fs_b, periods_b, bhs_low, bvs_low;
    logic prev_hs, prev_vs;
    logic [4:0] last_x, last_y;
    last_fs = -1; periods = 0; de_cnt = 0; vs_cnt = 0; line_idx = -1;
    line_de = 0; line_hs = 0; line_cyc = 0; last_x = 0; last_y = 0;
    last_fs_b = -1; periods_b = 0; bhs_low = 0; bvs_low = 0;
    prev_hs = hsync_a; prev_vs = vsync_a;
    en = 1'b1;
    for (int i = 0; i < 4 * TOT_A && (periods < 2 || periods_b < 2); i++) begin
      tick();
      checks++; if (obs_a !== ea) begin errors++; $display("FAIL frame_a @%0d: got %h want %h", cyc, obs_a, ea); end
      checks++; if (obs_b !== eb) begin errors++; $display("FAIL frame_b @%0d: got %h want %h", cyc, obs_b, eb); end
      if (ls_a) begin
        if (line_idx >= 0) begin
          checks++;
          if (line_de != ((line_idx < VA_A) ? HA_A : 0) || line_hs != HS_A) begin
            errors++; $display("FAIL line_counts line %0d: got de=%0d hs=%0d want de=%0d hs=%0d",
                               line_idx, line_de, line_hs, (line_idx < VA_A) ? HA_A : 0, HS_A);
          end
        end
        line_idx = fs_a ? 0 : ((line_idx >= 0) ? line_idx + 1 : -1);
        line_de = 0; line_hs = 0; line_cyc = cyc;
      end
      if (fs_a) begin
        if (last_fs >= 0) begin
          checks++;
          if (cyc - last_fs != TOT_A || de_cnt != HA_A * VA_A || vs_cnt != VS_A * HT_A) begin
            errors++; $display("FAIL frame_stats_a: got period=%0d de=%0d vs=%0d want %0d %0d %0d",
                               cyc - last_fs, de_cnt, vs_cnt, TOT_A, HA_A * VA_A, VS_A * HT_A);
          end
          checks++;
          if (last_x !== 5'(HA_A - 1) || last_y !== 5'(VA_A - 1)) begin
            errors++; $display("FAIL last_de_xy: got %0d,%0d want %0d,%0d", last_x, last_y, HA_A - 1, VA_A - 1);
          end
          periods++;
        end
        checks++;
        if (!(de_a === 1'b1 && x_a === 5'd0 && y_a === 5'd0)) begin
          errors++; $display("FAIL first_de_xy: got de=%b x=%0d y=%0d want 1 0 0", de_a, x_a, y_a);
        end
        last_fs = cyc; de_cnt = 0; vs_cnt = 0;
      end
      if (de_a) begin de_cnt++; line_de++; last_x = x_a; last_y = y_a; end
      if (hsync_a) line_hs++;
      if (vsync_a) vs_cnt++;
      if (hsync_a && !prev_hs && line_idx >= 0 && line_idx < VA_A) begin
        checks++;
        if (cyc - line_cyc != HA_A + HF_A) begin
          errors++; $display("FAIL hsync_offset: got %0d want %0d", cyc - line_cyc, HA_A + HF_A);
        end
      end
      if (vsync_a && !prev_vs && line_idx >= 0) begin
        checks++;
        if (ls_a !== 1'b1 || line_idx != VA_A + VF_A) begin
          errors++; $display("FAIL vsync_rise: got ls=%b line=%0d want 1 %0d", ls_a, line_idx, VA_A + VF_A);
        end
      end
      prev_hs = hsync_a; prev_vs = vsync_a;
      if (fs_b) begin
        if (last_fs_b >= 0) begin
          checks++;
          if (cyc - last_fs_b != TOT_B || bhs_low != HS_B * VT_B || bvs_low != VS_B * HT_B) begin
            errors++; $display("FAIL frame_stats_b: got period=%0d hs_low=%0d vs_low=%0d want %0d %0d %0d",
                               cyc - last_fs_b, bhs_low, bvs_low, TOT_B, HS_B * VT_B, VS_B * HT_B);
          end
          periods_b++;
        end
        last_fs_b = cyc; bhs_low = 0; bvs_low = 0;
      end
      if (!hsync_b) bhs_low++;
      if (!vsync_b) bvs_low++;
    end
    checks++;
    if (periods < 2 || periods_b < 2) begin
      errors++; $display("FAIL frames_timeout: got periods a=%0d b=%0d want 2 2", periods, periods_b);
    end
  endtask

  task automatic test_freeze();
    int fs_cyc;
    bit found;
    logic [14:0] snap;
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 2 * TOT_A && !found; i++) begin
      tick();
      if (ea[10]) found = 1;
    end
    fs_cyc = cyc;
    found = 0;
    for (int i = 0; i < 2 * TOT_A && !found; i++) begin
      tick();
      if (ea[9:5] == 5'd7 && ea[4:0] == 5'd5) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL freeze_seek: got no x=7,y=5 want found"); end
    en = 1'b0;
    snap = {ea[14:12], 2'b00, ea[9:0]};
    for (int i = 0; i < 37; i++) begin
      tick();
      checks++; if (obs_a !== snap) begin errors++; $display("FAIL freeze_hold_a: got %h want %h", obs_a, snap); end
      checks++; if (obs_b !== eb) begin errors++; $display("FAIL freeze_hold_b: got %h want %h", obs_b, eb); end
    end
    en = 1'b1;
    tick();
    checks++;
    if (x_a !== 5'd8 || y_a !== 5'd5) begin
      errors++; $display("FAIL resume_xy: got %0d,%0d want 8,5", x_a, y_a);
    end
    found = 0;
    for (int i = 0; i < 2 * TOT_A && !found; i++) begin
      tick();
      checks++; if (obs_a !== ea) begin errors++; $display("FAIL resume_a: got %h want %h", obs_a, ea); end
      if (fs_a) found = 1;
    end
    checks++;
    if (!found || cyc - fs_cyc != TOT_A + 37) begin
      errors++; $display("FAIL stall_period: got %0d want %0d", cyc - fs_cyc, TOT_A + 37);
    end
  endtask

  task automatic test_random_en();
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      tick();
      checks++; if (obs_a !== ea) begin errors++; $display("FAIL random_a @%0d: got %h want %h", cyc, obs_a, ea); end
      checks++; if (obs_b !== eb) begin errors++; $display("FAIL random_b @%0d: got %h want %h", cyc, obs_b, eb); end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 2 * TOT_A && !found; i++) begin
      tick();
      if (ea[9:5] == 5'd10 && ea[4:0] == 5'd6) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL areset_seek: got no x=10,y=6 want found"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (obs_a !== RST_A) begin errors++; $display("FAIL areset_now_a: got %h want %h", obs_a, RST_A); end
    checks++; if (obs_b !== RST_B) begin errors++; $display("FAIL areset_now_b: got %h want %h", obs_b, RST_B); end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (!(fs_a === 1'b1 && x_a === 5'd0 && y_a === 5'd0)) begin
      errors++; $display("FAIL areset_restart: got fs=%b x=%0d y=%0d want 1 0 0", fs_a, x_a, y_a);
    end
    checks++; if (obs_b !== eb) begin errors++; $display("FAIL areset_restart_b: got %h want %h", obs_b, eb); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_full_frames();
    test_freeze();
    test_random_en();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
